// File: rtl/multi_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, and counts retired instructions.
module multi_control #(
    parameter int         CNT_W    = 16,
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             pcwrite,
    output logic             pcwritecond,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             memtoreg,
    output logic             regdst,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsource,
    output logic             illegal,
    output logic             done,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] count_reg;

    // State register; reset returns to FETCH without waiting for a clock edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Retired-instruction counter, wraps naturally at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (done) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Next-state and Moore outputs, plus mem_ready-qualified enables
    always_comb begin
        state_next  = S_FETCH;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;
        illegal     = 1'b0;
        done        = 1'b0;

        case (state_reg)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                if (mem_ready) begin
                    irwrite    = 1'b1;
                    pcwrite    = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target while decoding
                alusrcb = 2'b11;
                if (op == OP_LW || op == OP_SW) begin
                    state_next = S_MEMADR;
                end else if (op == OP_RTYPE) begin
                    state_next = S_EXEC;
                end else if (op == OP_BEQ) begin
                    state_next = S_BRANCH;
                end else if (op == OP_J) begin
                    state_next = S_JUMP;
                end else if (op == OP_ADDI) begin
                    state_next = S_ADDIEX;
                end else begin
                    illegal    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memread    = 1'b1;
                iord       = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                done       = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    done       = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_MEMWR;
                end
            end
            S_EXEC: begin
                alusrca    = 1'b1;
                aluop      = 2'b10;
                state_next = S_RWB;
            end
            S_RWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                done       = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b11;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                done        = 1'b1;
                state_next  = S_FETCH;
            end
            S_JUMP: begin
                pcwrite    = 1'b1;
                pcsource   = 2'b10;
                done       = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                done       = 1'b1;
                state_next = S_FETCH;
            end
            default: begin
                // Unused encodings recover to FETCH with everything quiet
                state_next = S_FETCH;
            end
        endcase

        // While reset is held the state already reads FETCH; silence its
        // requests and enables so nothing reaches memory or the PC
        if (rst) begin
            memread  = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            done     = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign pc_en       = pcwrite | (pcwritecond & zero);
    assign state       = state_reg;
    assign instr_count = count_reg;

endmodule

// File: tb/tb_multi_control.sv
// Randomized scoreboard bench for multi_control: the driver derives each
// instruction's timeline and retire-cycle outputs from the opcode rules,
// a monitor pops and compares whenever the DUT retires or flags illegal.
module tb_multi_control;

    localparam int CNT_W = 4;
    localparam int NTXN  = 80;

    logic             clk;
    logic             rst;
    logic [5:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             pc_en, pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic             memtoreg, regdst, regwrite, alusrca, illegal, done;
    logic [1:0]       alusrcb, aluop, pcsource;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    multi_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource),
        .illegal(illegal), .done(done), .state(state), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             is_illegal;
        int               len;
        int               mr;
        int               mw;
        logic             pc_en;
        logic             regwrite;
        logic             memtoreg;
        logic             regdst;
        logic [1:0]       pcsource;
        logic [1:0]       aluop_end;
        logic [1:0]       aluop_prev;
        logic [CNT_W-1:0] count_before;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   active = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Monitor: accumulate per-instruction observations, compare on retire/illegal
    int         cyc = 0;
    int         mr_cnt = 0;
    int         mw_cnt = 0;
    logic [1:0] prev_aluop = 2'b00;
    exp_t       got;

    always @(negedge clk) begin
        if (active && !rst) begin
            cyc++;
            if (memread)  mr_cnt++;
            if (memwrite) mw_cnt++;
            if (done || illegal) begin
                if (sb.size() == 0) begin
                    check("unexpected_retire", 1, 0);
                end else begin
                    got = sb.pop_front();
                    check("illegal", int'(illegal), int'(got.is_illegal));
                    check("done", int'(done), int'(!got.is_illegal));
                    check("latency", cyc, got.len);
                    check("memread_cycles", mr_cnt, got.mr);
                    check("memwrite_cycles", mw_cnt, got.mw);
                    check("pc_en", int'(pc_en), int'(got.pc_en));
                    check("regwrite", int'(regwrite), int'(got.regwrite));
                    check("memtoreg", int'(memtoreg), int'(got.memtoreg));
                    check("regdst", int'(regdst), int'(got.regdst));
                    check("pcsource", int'(pcsource), int'(got.pcsource));
                    check("aluop_end", int'(aluop), int'(got.aluop_end));
                    check("aluop_prev", int'(prev_aluop), int'(got.aluop_prev));
                    check("count_before", int'(instr_count), int'(got.count_before));
                end
                cyc    = 0;
                mr_cnt = 0;
                mw_cnt = 0;
            end else if (cyc > 40) begin
                check("timeout_cycles", cyc, 0);
                cyc    = 0;
                mr_cnt = 0;
                mw_cnt = 0;
            end
            prev_aluop = aluop;
        end
    end

    localparam logic [5:0] OPS [6] = '{6'b000000, 6'b100011, 6'b101011,
                                       6'b000100, 6'b000010, 6'b001000};

    function automatic bit is_legal(input logic [5:0] o);
        foreach (OPS[i]) if (OPS[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    // Driver: random instructions, mem_ready timeline derived from the opcode
    logic [CNT_W-1:0] exp_count;
    initial begin
        exp_t e;
        int   k, fs, ms;
        bit   is_mem;

        rst = 1'b1; op = 6'd0; zero = 1'b0; mem_ready = 1'b1; exp_count = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", int'(state), 0);
        check("rst_count", int'(instr_count), 0);
        check("rst_memread", int'(memread), 0);
        check("rst_irwrite", int'(irwrite), 0);
        check("rst_pcwrite", int'(pcwrite), 0);
        check("rst_alusrcb", int'(alusrcb), 1);
        rst = 1'b0;
        active = 1'b1;

        for (int t = 0; t < NTXN; t++) begin
            k = $urandom_range(0, 6);
            if (k < 6) begin
                op = OPS[k];
            end else begin
                op = 6'($urandom_range(0, 63));
                while (is_legal(op)) op = 6'($urandom_range(0, 63));
            end
            zero = 1'($urandom_range(0, 1));
            fs   = $urandom_range(0, 2);
            ms   = $urandom_range(0, 2);
            is_mem = (k == 1) || (k == 2);

            e.is_illegal = (k == 6);
            e.mr         = fs + 1 + ((k == 1) ? ms + 1 : 0);
            e.mw         = (k == 2) ? ms + 1 : 0;
            e.pc_en      = (k == 3) ? zero : (k == 4);
            e.regwrite   = (k == 0) || (k == 1) || (k == 5);
            e.memtoreg   = (k == 1);
            e.regdst     = (k == 0);
            e.pcsource   = (k == 3) ? 2'b01 : ((k == 4) ? 2'b10 : 2'b00);
            e.aluop_end  = (k == 3) ? 2'b11 : 2'b00;
            e.aluop_prev = (k == 0) ? 2'b10 : 2'b00;
            e.count_before = exp_count;
            case (k)
                0:       e.len = fs + 4;
                1:       e.len = fs + 5 + ms;
                2:       e.len = fs + 4 + ms;
                3, 4:    e.len = fs + 3;
                5:       e.len = fs + 4;
                default: e.len = fs + 2;
            endcase
            if (k < 6) exp_count = exp_count + CNT_W'(1);
            sb.push_back(e);
            $display("txn %0d op %b zero %0d fstall %0d mstall %0d len %0d count %0d",
                     t, op, zero, fs, is_mem ? ms : 0, e.len, e.count_before);

            for (int c = 0; c < e.len; c++) begin
                if (c < fs)
                    mem_ready = 1'b0;
                else if (is_mem && c >= fs + 3 && c < fs + 3 + ms)
                    mem_ready = 1'b0;
                else
                    mem_ready = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        active = 1'b0;
        check("queue_drained", sb.size(), 0);
        check("final_count", int'(instr_count), int'(exp_count));
        check("final_state", int'(state), 0);

        // Stall a store in its write phase, then reset asynchronously
        op = 6'b101011;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sw_stall_state", int'(state), 5);
        check("sw_stall_memwrite", int'(memwrite), 1);
        check("sw_stall_done", int'(done), 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_memwrite", int'(memwrite), 0);
        check("async_rst_state", int'(state), 0);
        check("async_rst_count", int'(instr_count), 0);
        check("async_rst_memread", int'(memread), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b1;
        op = 6'b000000;
        @(posedge clk); #1;
        check("post_rst_decode", int'(state), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
